// File: rtl/seq_tx_10110.sv
// Serial frame transmitter: prefixes each payload word with the 10110 sync pattern and shifts it out MSB first.
// Optional even-parity bit after the payload is enabled by defining SEQ_TX_PARITY_EN.
module seq_tx_10110 #(
  parameter int         DATA_W   = 8,
  parameter int         GAP_LEN  = 2,
  parameter logic [4:0] SYNC_PAT = 5'b10110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              seq_out,
  output logic              frame_active,
  output logic              tx_done,
  output logic [2:0]        state_dbg
);

  // Handshake: a word is taken on a rising clk edge where data_valid and
  // data_ready are both 1; data_in must stay stable until that edge, and
  // data_valid is ignored whenever data_ready is 0.

  localparam int CNT_MAX = (DATA_W > 5) ? DATA_W : 5;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(4);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_LEN - 1);

`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        sync_sh;
`ifdef SEQ_TX_PARITY_EN
  logic              parity;
`endif

  assign state_dbg = state;

  // Every output register is loaded with the value for the cycle that the
  // next state represents, so seq_out always shows the bit indexed by cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      gap_cnt      <= '0;
      shreg        <= '0;
      sync_sh      <= '0;
`ifdef SEQ_TX_PARITY_EN
      parity       <= 1'b0;
`endif
      seq_out      <= 1'b0;
      frame_active <= 1'b0;
      tx_done      <= 1'b0;
      data_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          seq_out      <= 1'b0;
          frame_active <= 1'b0;
          tx_done      <= 1'b0;
          data_ready   <= 1'b1;
          if (data_valid && data_ready) begin
            shreg        <= data_in;
`ifdef SEQ_TX_PARITY_EN
            parity       <= ^data_in;
`endif
            sync_sh      <= SYNC_PAT[3:0];
            cnt          <= '0;
            state        <= SYNC;
            seq_out      <= SYNC_PAT[4];
            frame_active <= 1'b1;
            data_ready   <= 1'b0;
          end
        end

        SYNC: begin
          if (cnt == LAST_SYNC) begin
            state   <= DATA;
            cnt     <= '0;
            seq_out <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            tx_done <= !PAR_EN && (DATA_W == 1);
          end else begin
            cnt     <= cnt + CNT_W'(1);
            seq_out <= sync_sh[3];
            sync_sh <= {sync_sh[2:0], 1'b0};
          end
        end

        DATA: begin
          if (cnt == LAST_DATA) begin
`ifdef SEQ_TX_PARITY_EN
            state        <= PARITY;
            seq_out      <= parity;
            frame_active <= 1'b1;
            tx_done      <= 1'b1;
`else
            state        <= GAP;
            gap_cnt      <= '0;
            seq_out      <= 1'b0;
            frame_active <= 1'b0;
            tx_done      <= 1'b0;
`endif
          end else begin
            cnt     <= cnt + CNT_W'(1);
            seq_out <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            tx_done <= !PAR_EN && ((cnt + CNT_W'(1)) == LAST_DATA);
          end
        end

`ifdef SEQ_TX_PARITY_EN
        PARITY: begin
          state        <= GAP;
          gap_cnt      <= '0;
          seq_out      <= 1'b0;
          frame_active <= 1'b0;
          tx_done      <= 1'b0;
        end
`endif

        GAP: begin
          seq_out      <= 1'b0;
          frame_active <= 1'b0;
          tx_done      <= 1'b0;
          if (gap_cnt == LAST_GAP) begin
            state      <= IDLE;
            data_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state        <= IDLE;
          seq_out      <= 1'b0;
          frame_active <= 1'b0;
          tx_done      <= 1'b0;
          data_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx_10110.sv
// Bench for seq_tx_10110: a queue-based frame model predicts every line cycle; a 10110 detector checks sync alignment.
module tb_seq_tx_10110;

  localparam int         DATA_W  = 8;
  localparam int         GAP_LEN = 2;
  localparam logic [4:0] SYNC    = 5'b10110;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              seq_out;
  logic              frame_active;
  logic              tx_done;
  logic [2:0]        state_dbg;

  int total = 0;
  int bad   = 0;
  int accept_cnt = 0;

  seq_tx_10110 #(.DATA_W(DATA_W), .GAP_LEN(GAP_LEN), .SYNC_PAT(SYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .seq_out      (seq_out),
    .frame_active (frame_active),
    .tx_done      (tx_done),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: each entry is {seq_out, frame_active, tx_done, data_ready, sync_seen}
  logic [4:0] exp_q[$];
  logic [4:0] cur = 5'b0;
  logic       m_bits[$];
  logic       m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur = 5'b0;
    end else begin
      m_acc = data_valid && cur[1];
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = 5'b00010;
      if (m_acc) begin
        m_bits.delete();
        for (int i = 4; i >= 0; i--) m_bits.push_back(SYNC[i]);
        for (int i = DATA_W - 1; i >= 0; i--) m_bits.push_back(data_in[i]);
`ifdef SEQ_TX_PARITY_EN
        m_bits.push_back(^data_in);
`endif
        for (int i = 0; i < m_bits.size(); i++)
          exp_q.push_back({m_bits[i], 1'b1, 1'(i == m_bits.size() - 1), 1'b0, 1'(i == 5)});
        repeat (GAP_LEN) exp_q.push_back(5'b0);
        cur = exp_q.pop_front();
        accept_cnt++;
      end
    end
  end

  // Receive-side 10110 detector fed from the serial line
  logic [4:0] hist;
  always @(posedge clk or negedge rst) begin
    if (!rst) hist <= 5'b0;
    else      hist <= {hist[3:0], seq_out};
  end
  wire det = (hist == 5'b10110);

  // scoreboard: every cycle, sampled on the falling edge
  always @(negedge clk) begin
    chk("line", {4'b0, seq_out, frame_active, tx_done, data_ready}, {4'b0, cur[4:1]});
    if (cur[0]) chk("detect", {7'b0, det}, 8'd1);
  end

  // driver tasks
  task automatic send_word(input logic [DATA_W-1:0] w, input bit keep_valid);
    int start;
    int n;
    start = accept_cnt;
    n = 0;
    @(negedge clk);
    data_in = w;
    data_valid = 1'b1;
    while (accept_cnt == start && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {7'b0, 1'(accept_cnt != start)}, 8'd1);
    if (!keep_valid) data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    idle(3);
    chk("reset_outs", {4'b0, seq_out, frame_active, tx_done, data_ready}, 8'd0);
    rst = 1'b1;
    idle(20);

    // directed single frames
    send_word(8'hA5, 1'b0);
    idle(20);
    send_word(8'h07, 1'b0);
    idle(20);

    // back-to-back with valid held; data_in wiggles while not ready
    send_word(8'h0F, 1'b1);
    data_in = 8'h3C;
    idle(4);
    send_word(8'hF0, 1'b0);
    idle(20);

    // random payloads with random spacing
    for (int i = 0; i < 16; i++) begin
      send_word(DATA_W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      data_in = DATA_W'($urandom);
      if ($urandom_range(0, 1) == 1) data_valid = 1'b0;
      idle($urandom_range(0, 3));
    end
    data_valid = 1'b0;
    idle(20);

    // async abort during the third payload bit
    send_word(8'hC3, 1'b0);
    idle(7);
    chk("pre_abort_active", {7'b0, frame_active}, 8'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_now", {5'b0, seq_out, frame_active, data_ready}, 8'd0);
    idle(2);
    rst = 1'b1;
    idle(3);
    send_word(DATA_W'($urandom_range(0, 255)), 1'b0);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_tx_10110.md
Name: seq_tx_10110

Overview:
- Serial frame transmitter: accepts a parallel word via valid/ready handshake and shifts it out one bit per clock.
- Each frame is prefixed with the sync pattern 10110, so a downstream 10110 sequence detector can locate frame starts.
- Sits on the transmit side of the serial link, driving seq_in of the receive-side detector.
- Line idles at 0 between frames.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- GAP_LEN, 2, number of forced 0 bits after each frame before returning to IDLE (>=1).
- SYNC_PAT, 5'b10110, sync pattern, sent MSB first; width fixed at 5.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  DATA_W  payload word; sampled on accept.
- data_valid  input  1  upstream has a word; must hold data_in stable until accepted.
- data_ready  output  1  block can accept; accept = data_valid & data_ready at a rising clk edge.
- seq_out  output  1  serial line, registered.
- frame_active  output  1  high while seq_out carries a sync, payload or parity bit.
- tx_done  output  1  one-cycle pulse, coincident with the last frame bit on seq_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; shift register and counters cleared.
  - seq_out=0, frame_active=0, tx_done=0, data_ready=0 while rst=0.
  - First clk edge after release: data_ready=1.
- Reset mid-frame: aborts immediately (async). No tx_done pulse. The partial word is discarded and not retransmitted.
- States:
  - IDLE: seq_out=0, data_ready=1. On accept: load data_in into the shift register, bit counter=0, go to SYNC.
  - SYNC: 5 cycles. seq_out = SYNC_PAT[4-cnt], i.e. 1,0,1,1,0. After cnt=4, go to DATA with cnt=0.
  - DATA: DATA_W cycles. seq_out = payload bits, MSB first (data_in[DATA_W-1] first). After last bit, go to PARITY if enabled, else GAP.
  - PARITY: see Optional Feature.
  - GAP: GAP_LEN cycles, seq_out=0, then go to IDLE.
- Outputs during a frame:
  - data_ready=0 in every state except IDLE; data_valid is ignored there.
  - frame_active=1 in SYNC, DATA and PARITY.
- Latency: accept at edge k -> first sync bit on seq_out after edge k, i.e. valid in cycle k+1.
- Frame length:
  - Without parity: 5+DATA_W bits on the line.
  - Minimum spacing between frames: GAP_LEN zeros plus 1 IDLE zero.
  - Back-to-back accept with data_valid held high: next frame's first sync bit follows exactly GAP_LEN+1 zero cycles.
- Outputs are registered and driven from the state/shift register (Moore style); no combinational path from data_valid to seq_out.
- Payload may itself contain 10110; no bit stuffing is done. Upstream is responsible for that.
- Bit counter width is clog2(max(5,DATA_W)) and must not wrap mid-state.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - PARITY state (1 cycle) inserted between DATA and GAP.
  - seq_out = even parity of the accepted payload (XOR of all DATA_W bits), computed at accept.
  - frame_active=1 during PARITY; tx_done pulses on the parity bit.
  - Frame length becomes 6+DATA_W.
- Undefined: no PARITY state or parity logic; tx_done pulses on the last payload bit.

Test Plan:
- Reset release, data_valid=0 for 20 cycles -> seq_out=0, frame_active=0, tx_done=0 throughout; data_ready=1 from the first edge after release.
- Accept data_in=8'hA5, no parity, GAP_LEN=2 -> seq_out over cycles k+1..k+13 = 1,0,1,1,0,1,0,1,0,0,1,0,1, then 0,0,0. frame_active high exactly 13 cycles; tx_done high only at k+13; data_ready low k+1..k+15.
- data_valid held high with words 8'h0F then 8'hF0 -> the two frames are separated by exactly 3 zero bits; second payload = 1,1,1,1,0,0,0,0; data_in change while data_ready=0 has no effect.
- SEQ_TX_PARITY_EN defined, data_in=8'h07 -> parity bit 1 follows payload 0,0,0,0,0,1,1,1; frame length 14; tx_done on the parity bit. With data_in=8'hA5 -> parity bit 0.
- rst=0 asserted asynchronously in the 3rd payload bit -> seq_out, frame_active and data_ready go 0 without waiting for clk; no tx_done. After release: IDLE, next accepted frame starts with a clean 1,0,1,1,0.
- Serial loopback into a 10110 detector, 16 random payloads -> a detection follows every sync pattern, aligned one cycle after the final sync 0.
